// File: rtl/uart_pkg.sv
// uart_pkg -- shared types for the UART receive controller.
//   rx_state_t : receiver FSM states
//   rx_entry_t : one received frame as stored in the RX queue
//   data_bits(): decode of the 2-bit data_bit_num setting into a bit count
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rx_entry_t;

    // 00/01/10/11 -> 5/6/7/8 data bits
    function automatic logic [3:0] data_bits(input logic [1:0] sel);
        return 4'd5 + {2'b00, sel};
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if -- read-side bundle of the UART receive controller.
//   master : receiver side (drives data/status, takes rd_en)
//   slave  : consumer side (drives rd_en, takes data/status)
// Signals: rd_en, rx_valid, rx_data[7:0], parity_error, frame_error,
//          overrun, break_det, cts_n, fifo_level[$clog2(DEPTH):0]
interface uart_rx_ctrl_if #(
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          rd_en;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          parity_error;
    logic          frame_error;
    logic          overrun;
    logic          break_det;
    logic          cts_n;
    logic [LW-1:0] fifo_level;

    modport master (
        input  rd_en,
        output rx_valid, rx_data, parity_error, frame_error,
               overrun, break_det, cts_n, fifo_level
    );

    modport slave (
        output rd_en,
        input  rx_valid, rx_data, parity_error, frame_error,
               overrun, break_det, cts_n, fifo_level
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- first-word-fall-through queue of received frames.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push, push_entry  write request and entry
//   pop               read request (ignored when empty)
//   head              entry at the head (valid while !empty)
//   full, empty       occupancy flags
//   level             entries held, 0..DEPTH
// A push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  rx_entry_t              push_entry,
    input  logic                   pop,
    output rx_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    rx_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    // NOTE: storage carries no reset; entries are only observed once written,
    // and leaving them unreset lets the array map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_entry;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;   // power-of-2 depth: natural wrap
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- oversampling UART receiver with receive queue and CTS.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   tick                   oversample enable, OSR ticks per bit
//   rx                     asynchronous serial line, idle high
//   data_bit_num           00/01/10/11 = 5/6/7/8 data bits
//   stop_bit_num           0 = one stop bit, 1 = two
//   parity_en, parity_type parity enable; 0 = even, 1 = odd
//   bus (master)           rd_en in; rx_valid, rx_data, parity_error,
//                          frame_error, overrun, break_det, cts_n, fifo_level out
// Build option UART_RX_FIFO_EN: defined -> DEPTH-entry FIFO (uart_rx_fifo);
// undefined -> single holding register with a CTS threshold of one entry.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OSR        = 16,
    parameter int DEPTH      = 8,
    parameter int CTS_THRESH = DEPTH - 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tick,
    input  logic           rx,
    input  logic [1:0]     data_bit_num,
    input  logic           stop_bit_num,
    input  logic           parity_en,
    input  logic           parity_type,
    uart_rx_ctrl_if.master bus
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(OSR);
    localparam logic [CW-1:0] MID_A = CW'(OSR/2 - 1);
    localparam logic [CW-1:0] MID_B = CW'(OSR/2);
    localparam logic [CW-1:0] MID_C = CW'(OSR/2 + 1);
    localparam logic [CW-1:0] LAST  = CW'(OSR - 1);

    // ---------------- synchroniser and edge detect ----------------
    logic [1:0] sync;
    logic       rx_s;
    logic       rx_d;

    assign rx_s = sync[1];

    // ---------------- receiver FSM state ----------------
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [3:0]    nbits;
    logic          stop2;
    logic          par_en;
    logic          par_odd;
    logic [7:0]    data_q;
    logic [1:0]    samp;
    logic          any_one;
    logic          perr_q;
    logic          ferr_q;
    logic          stop_idx;
    logic          break_q;

    logic          mid_a, mid_b, mid_c, bit_end;
    logic          maj;
    logic          last_stop;
    logic          push;
    logic          brk;
    rx_entry_t     push_entry;

    assign mid_a   = tick && (cnt == MID_A);
    assign mid_b   = tick && (cnt == MID_B);
    assign mid_c   = tick && (cnt == MID_C);
    assign bit_end = tick && (cnt == LAST);

    // NOTE: every always_comb output gets a default first, so no path through
    // the block can leave a value held and infer a latch.
    always_comb begin
        maj        = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
        last_stop  = (state == STOP) && mid_c && (stop_idx == stop2);
        // A frame whose every sampled bit is zero is a break, not data.
        push       = last_stop && (any_one | maj);
        brk        = last_stop && !(any_one | maj);
        push_entry = '{data: data_q, perr: perr_q, ferr: ferr_q | ~maj};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= 2'b11;
            rx_d     <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            nbits    <= '0;
            stop2    <= 1'b0;
            par_en   <= 1'b0;
            par_odd  <= 1'b0;
            data_q   <= '0;
            samp     <= '0;
            any_one  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            stop_idx <= 1'b0;
            break_q  <= 1'b0;
        end else begin
            sync    <= {sync[0], rx};
            rx_d    <= rx_s;
            break_q <= 1'b0;

            if (state != IDLE && tick)
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            if (mid_a) samp[0] <= rx_s;
            if (mid_b) samp[1] <= rx_s;

            case (state)
                IDLE: begin
                    // A falling edge needs the line high first, so after a
                    // break the receiver naturally waits for rx to return high.
                    if (rx_d && !rx_s) begin
                        state    <= START;
                        cnt      <= '0;
                        nbits    <= data_bits(data_bit_num);
                        stop2    <= stop_bit_num;
                        par_en   <= parity_en;
                        par_odd  <= parity_type;
                        data_q   <= '0;
                        bit_idx  <= '0;
                        any_one  <= 1'b0;
                        perr_q   <= 1'b0;
                        ferr_q   <= 1'b0;
                        stop_idx <= 1'b0;
                    end
                end
                START: begin
                    if (mid_a && rx_s) begin
                        state <= IDLE;          // false start
                        cnt   <= '0;
                    end else if (bit_end) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    if (mid_c) begin
                        data_q[bit_idx] <= maj;
                        any_one         <= any_one | maj;
                    end
                    if (bit_end) begin
                        if ({1'b0, bit_idx} == nbits - 4'd1)
                            state <= par_en ? PARITY : STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end
                end
                PARITY: begin
                    if (mid_c) begin
                        perr_q  <= (maj != ((^data_q) ^ par_odd));
                        any_one <= any_one | maj;
                    end
                    if (bit_end) state <= STOP;
                end
                STOP: begin
                    if (last_stop) begin
                        // Return at mid stop bit so a start edge in the
                        // remaining half bit is caught.
                        state   <= IDLE;
                        cnt     <= '0;
                        break_q <= brk;
                    end else begin
                        if (mid_c) begin
                            ferr_q  <= ferr_q | ~maj;
                            any_one <= any_one | maj;
                        end
                        if (bit_end) stop_idx <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- receive queue ----------------
    rx_entry_t     head;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          pop_ok;
    logic          overrun_q;
    logic          cts_q;

    assign pop_ok = bus.rd_en && !empty;

`ifdef UART_RX_FIFO_EN
    localparam int THR = CTS_THRESH;

    uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (bus.rd_en),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .level      (level)
    );
`else
    localparam int THR = 1;

    logic hold_valid;

    assign full  = hold_valid;
    assign empty = !hold_valid;
    assign level = LW'(hold_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            hold_valid <= 1'b0;
        end else begin
            if (pop_ok) hold_valid <= 1'b0;
            if (push && (!hold_valid || pop_ok)) begin
                head       <= push_entry;
                hold_valid <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
            cts_q     <= 1'b0;
        end else begin
            // Push and pop together on a full queue are both accepted.
            if (push && full && !pop_ok) overrun_q <= 1'b1;
            else if (pop_ok)             overrun_q <= 1'b0;
            cts_q <= (level >= LW'(THR));
        end
    end

    assign bus.rx_valid     = !empty;
    assign bus.rx_data      = empty ? 8'h00 : head.data;
    assign bus.parity_error = !empty && head.perr;
    assign bus.frame_error  = !empty && head.ferr;
    assign bus.overrun      = overrun_q;
    assign bus.break_det    = break_q;
    assign bus.cts_n        = cts_q;
    assign bus.fifo_level   = level;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl -- scoreboard bench for uart_rx_ctrl.
// Stimulus pushes expected frames into a queue; a monitor pops and compares
// whenever rx_valid is presented and reading is enabled.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int OSR     = 16;
    localparam int DEPTH   = 8;
    localparam int TP      = 4;              // clk cycles per tick
    localparam int BIT_CLK = OSR * TP;
`ifdef UART_RX_FIFO_EN
    localparam int TB_CAP  = DEPTH;
    localparam int TB_THR  = DEPTH - 2;
`else
    localparam int TB_CAP  = 1;
    localparam int TB_THR  = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick = 1'b0;
    logic       rx;
    logic [1:0] data_bit_num;
    logic       stop_bit_num;
    logic       parity_en;
    logic       parity_type;

    uart_rx_ctrl_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_ctrl #(.OSR(OSR), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .rx           (rx),
        .data_bit_num (data_bit_num),
        .stop_bit_num (stop_bit_num),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            div  = (div == TP - 1) ? 0 : div + 1;
            tick = (div == 0);
        end
    end

    int        vectors    = 0;
    int        miscompares = 0;
    int        break_cnt  = 0;
    bit        auto_read  = 1'b0;
    int        pop_credit = 0;
    rx_entry_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare the FIFO head against the scoreboard and pop it.
    initial begin
        rx_entry_t e;
        bus.rd_en = 1'b0;
        forever begin
            @(negedge clk);
            bus.rd_en = 1'b0;
            if (rst_n && bus.rx_valid && (auto_read || pop_credit > 0)) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got rx_data %0h, expected no frame", bus.rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data",      32'(bus.rx_data),      32'(e.data));
                    check("parity_error", 32'(bus.parity_error), 32'(e.perr));
                    check("frame_error",  32'(bus.frame_error),  32'(e.ferr));
                end
                bus.rd_en = 1'b1;
                if (pop_credit > 0) pop_credit--;
            end
        end
    end

    always @(negedge clk) if (bus.break_det) break_cnt++;

    task automatic expect_frame(input logic [7:0] d, input logic perr, input logic ferr);
        exp_q.push_back('{data: d, perr: perr, ferr: ferr});
    endtask

    task automatic cfg(input logic [1:0] nb, input logic st, input logic pe, input logic pt);
        data_bit_num = nb;
        stop_bit_num = st;
        parity_en    = pe;
        parity_type  = pt;
    endtask

    task automatic send_bit(input logic v);
        @(negedge clk);
        rx = v;
        repeat (BIT_CLK - 1) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        @(negedge clk);
        rx = 1'b1;
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                              input logic pbit, input logic s1, input logic two,
                              input logic s2);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(s1);
        if (two) send_bit(s2);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int brk0;
        rst_n = 1'b0;
        rx    = 1'b1;
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rx_valid",     32'(bus.rx_valid),     32'd0);
        check("rst_rx_data",      32'(bus.rx_data),      32'd0);
        check("rst_parity_error", 32'(bus.parity_error), 32'd0);
        check("rst_frame_error",  32'(bus.frame_error),  32'd0);
        check("rst_overrun",      32'(bus.overrun),      32'd0);
        check("rst_break_det",    32'(bus.break_det),    32'd0);
        check("rst_fifo_level",   32'(bus.fifo_level),   32'd0);
        check("rst_cts_n",        32'(bus.cts_n),        32'd0);
        rst_n = 1'b1;
        idle_bits(2);

        // 8N1 0xA5, held in the queue first
        expect_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle_bits(1);
        check("a5_rx_valid",   32'(bus.rx_valid),   32'd1);
        check("a5_fifo_level", 32'(bus.fifo_level), 32'd1);
        check("a5_cts_n",      32'(bus.cts_n),      32'(1 >= TB_THR));
        auto_read = 1'b1;
        idle_bits(1);
        check("a5_level_after_read", 32'(bus.fifo_level), 32'd0);

        // 7E1 0x41 with wrong parity bit 1; then 7O1 with correct parity 1
        cfg(2'b10, 1'b0, 1'b1, 1'b0);
        expect_frame(8'h41, 1'b1, 1'b0);
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        idle_bits(1);
        cfg(2'b10, 1'b0, 1'b1, 1'b1);
        expect_frame(8'h41, 1'b0, 1'b0);
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        idle_bits(1);

        // 6N1 0x2B; 5O1 0x13 (three ones -> odd parity bit 0)
        cfg(2'b01, 1'b0, 1'b0, 1'b0);
        expect_frame(8'h2B, 1'b0, 1'b0);
        send_frame(8'h2B, 6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cfg(2'b00, 1'b0, 1'b1, 1'b1);
        expect_frame(8'h13, 1'b0, 1'b0);
        send_frame(8'h13, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle_bits(1);

        // Glitch: low for 4 ticks, must not produce a frame
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rx = 1'b0;
        repeat (4 * TP) @(negedge clk);
        idle_bits(3);
        check("glitch_level", 32'(bus.fifo_level), 32'd0);

        // 8N1 0xFF with zero stop bit -> frame error
        expect_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_bits(2);

        // 8N2 0x5A, second stop bit zero -> frame error
        cfg(2'b11, 1'b1, 1'b0, 1'b0);
        expect_frame(8'h5A, 1'b0, 1'b1);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle_bits(2);

        // Break: line low for 12 bit times
        brk0 = break_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (12 * BIT_CLK) @(negedge clk);
        idle_bits(2);
        check("break_pulse_cycles", 32'(break_cnt - brk0), 32'd1);
        check("break_level",        32'(bus.fifo_level),   32'd0);
        wait_drain();

        // Overrun: fill without reading, one frame past capacity
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        auto_read = 1'b0;
        for (int i = 0; i <= TB_CAP; i++) begin
            if (i < TB_CAP) expect_frame(8'(8'h10 + i), 1'b0, 1'b0);
            send_frame(8'(8'h10 + i), 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            if (i == TB_THR - 2) check("cts_below_thresh", 32'(bus.cts_n), 32'd0);
            if (i == TB_THR - 1) begin
                check("cts_level_at_thresh", 32'(bus.fifo_level), 32'(TB_THR));
                check("cts_at_thresh",       32'(bus.cts_n),      32'd1);
            end
        end
        idle_bits(1);
        check("ovr_level",   32'(bus.fifo_level), 32'(TB_CAP));
        check("ovr_overrun", 32'(bus.overrun),    32'd1);
        check("ovr_cts_n",   32'(bus.cts_n),      32'd1);
        pop_credit = 1;
        begin
            int n;
            n = 0;
            while (pop_credit != 0 && n < 1000) begin
                @(negedge clk);
                n++;
            end
        end
        check("pop_credit_used", 32'(pop_credit), 32'd0);
        repeat (3) @(negedge clk);
        check("ovr_cleared",     32'(bus.overrun),    32'd0);
        check("ovr_level_after", 32'(bus.fifo_level), 32'(TB_CAP - 1));
        auto_read = 1'b1;
        wait_drain();

        // Reset during DATA of 0x3C (bits 0,0,1 sent), then 0x55
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk);
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(2);
        check("midrst_level", 32'(bus.fifo_level), 32'd0);
        expect_frame(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle_bits(2);
        wait_drain();
        check("final_level", 32'(bus.fifo_level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter OSR, 16, oversample ticks per bit (even, 8..32).
REQ-002 Parameter DEPTH, 8, RX FIFO entries (power of 2, >=4).
REQ-003 Parameter CTS_THRESH, DEPTH-2, FIFO level at which cts_n deasserts.
REQ-004 clk  input  1  clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 tick  input  1  oversample enable, one clk wide, OSR per bit.
REQ-007 rx  input  1  serial line, asynchronous, idle high.
REQ-008 data_bit_num  input  2  00/01/10/11 = 5/6/7/8 data bits.
REQ-009 stop_bit_num  input  1  0 = one stop bit, 1 = two.
REQ-010 parity_en, parity_type  input  1 each  parity enable; 0 = even, 1 = odd.
REQ-011 rd_en  input  1  pop FIFO head.
REQ-012 rx_valid  output  1  FIFO non-empty.
REQ-013 rx_data  output  8  head data, right-justified, unused upper bits 0.
REQ-014 parity_error, frame_error  output  1 each  flags of the head entry.
REQ-015 overrun  output  1  sticky, frame dropped on full FIFO.
REQ-016 break_det  output  1  one-clk pulse on break frame.
REQ-017 cts_n  output  1  flow control, low = send allowed.
REQ-018 fifo_level  output  $clog2(DEPTH)+1  entries held.

Function
REQ-019 rx SHALL pass a 2-FF synchroniser; all logic uses the synchronised value.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; tick counter counts 0..OSR-1 and resets on state entry.
REQ-021 IDLE->START on a synchronised falling edge; START SHALL check rx at tick OSR/2-1, low -> DATA, high -> IDLE (false start, nothing pushed).
REQ-022 Each bit SHALL be the majority of samples at ticks OSR/2-1, OSR/2, OSR/2+1 of its bit period; data LSB first.
REQ-023 DATA->PARITY (parity_en=1) or STOP after the configured bit count; PARITY->STOP after one bit.
REQ-024 Expected parity = XOR of data bits, inverted when parity_type=1; a mismatch sets the entry's parity_error.
REQ-025 A zero first stop bit, or zero second stop bit with stop_bit_num=1, SHALL set frame_error.
REQ-026 After the last stop-bit sample the frame SHALL be pushed the same cycle and FSM returns to IDLE, so a start edge in the remaining half stop bit is accepted.
REQ-027 All data, parity and stop samples zero SHALL pulse break_det and push nothing; FSM waits in IDLE for rx high before accepting a new start.
REQ-028 FIFO is first-word-fall-through; rx_data and flags valid while rx_valid=1; rd_en with rx_valid=0 ignored.
REQ-029 Push with FIFO full and no rd_en SHALL drop the frame and set overrun; simultaneous push and pop when full SHALL accept both, no overrun.
REQ-030 overrun SHALL clear on the first accepted rd_en after being set.
REQ-031 cts_n SHALL be 1 when fifo_level >= CTS_THRESH, else 0, registered.
REQ-032 Config inputs SHALL be sampled at START entry and held for the frame.

Reset
REQ-033 On rst_n low: FSM IDLE, counters 0, FIFO empty, rx_valid/rx_data/parity_error/frame_error/overrun/break_det/fifo_level 0, cts_n 0, synchroniser 1.
REQ-034 Reset mid-frame SHALL discard the partial frame; no push after release.

Configuration
REQ-035 With UART_RX_FIFO_EN defined, FIFO of DEPTH entries as above; undefined, a single holding register (effective DEPTH=1, CTS_THRESH=1), cts_n high while full, overrun on push when full.

Structure
REQ-036 Package uart_pkg SHALL hold the state enum, rx_entry_t struct {data[7:0], perr, ferr} and data-bit-count decode function.
REQ-037 FIFO SHALL be sub-module uart_rx_fifo (storage, pointers, level) instantiated under UART_RX_FIFO_EN.

Verification
REQ-038 8N1, OSR=16, byte 0xA5 -> rx_valid, rx_data=0xA5, both flags 0, fifo_level=1.
REQ-039 7E1, 0x41 with parity bit 1 -> rx_data=0x41, parity_error=1.
REQ-040 Glitch low for 4 ticks in IDLE -> no push, FSM back to IDLE.
REQ-041 8N2, second stop bit 0 -> frame_error=1; 12-bit-time line low -> break_det pulse, level unchanged.
REQ-042 DEPTH=8, 9 frames without rd_en -> cts_n=1 at level 6, 9th dropped, overrun=1; one rd_en -> overrun=0, level 7.
REQ-043 rst_n low in DATA of 0x3C, then send 0x55 -> only 0x55 received.
